// File: rtl/lea_job_arbiter.sv
// Two-requester round-robin job sequencer for a shared LEA-192 datapath.
// Holds engine operands for LATENCY cycles, then returns a tagged result.
module lea_job_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_mode,
  input  logic [191:0] req0_key,
  input  logic [127:0] req0_text,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_mode,
  input  logic [191:0] req1_key,
  input  logic [127:0] req1_text,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         eng_mode,
  output logic [191:0] eng_key,
  output logic [127:0] eng_din,
  input  logic [127:0] eng_dout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       accept;

  // Contention goes to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) && grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      eng_mode   <= 1'b0;
      eng_key    <= '0;
      eng_din    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            eng_mode   <= grant ? req1_mode : req0_mode;
            eng_key    <= grant ? req1_key  : req0_key;
            eng_din    <= grant ? req1_text : req0_text;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
            state      <= RUN;
          end
        end
        RUN: begin
          if (cnt == 8'd0) begin
            rsp_data  <= eng_dout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lea_job_arbiter.sv
// Scoreboard bench for lea_job_arbiter with an XOR engine model.
// Instance a uses LATENCY=4, instance b uses LATENCY=1.
module tb_lea_job_arbiter;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } exp_t;

  localparam logic [191:0] K1 = {64'h1111, 128'hdeadbeef_01234567_89abcdef_cafef00d};
  localparam logic [127:0] X1 = 128'h55555555_aaaaaaaa_12345678_9abcdef0;
  localparam logic [191:0] KA = {64'ha5a5, 128'h00000000_00000000_00000000_000000ff};
  localparam logic [127:0] XA = 128'h01010101_01010101_01010101_01010101;
  localparam logic [191:0] KB = {64'h5a5a, 128'hffff0000_ffff0000_ffff0000_ffff0000};
  localparam logic [127:0] XB = 128'h00000000_00000000_00000000_00000001;
  localparam logic [191:0] K2 = {64'h0123456789abcdef, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e187};
  localparam logic [127:0] X2 = 128'h20212223_24252627_28292a2b_2c2d2e2f;
  localparam logic [191:0] K3 = {64'h3333, 128'h13579bdf_2468ace0_fedcba98_76543210};
  localparam logic [127:0] X3 = 128'hffffffff_00000000_ffffffff_00000000;
  localparam logic [191:0] K4 = {64'h4444, 128'h0};
  localparam logic [127:0] X4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [191:0] K5 = {64'h5555, 128'hc0ffee00_c0ffee00_c0ffee00_c0ffee00};
  localparam logic [127:0] X5 = 128'h0badf00d_0badf00d_0badf00d_0badf00d;
  localparam logic [191:0] K6 = {64'h6666, 128'h00112233_44556677_8899aabb_ccddeeff};
  localparam logic [127:0] X6 = 128'hfedcba98_76543210_01234567_89abcdef;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         a_r0v, a_r0r, a_r0m, a_r1v, a_r1r, a_r1m;
  logic [191:0] a_r0k, a_r1k, a_ek;
  logic [127:0] a_r0t, a_r1t, a_rd, a_ed, a_eo;
  logic         a_rv, a_rr, a_rid, a_em, a_busy;

  logic         b_r0v, b_r0r, b_r0m, b_r1v, b_r1r, b_r1m;
  logic [191:0] b_r0k, b_r1k, b_ek;
  logic [127:0] b_r0t, b_r1t, b_rd, b_ed, b_eo;
  logic         b_rv, b_rr, b_rid, b_em, b_busy;

  assign a_eo = a_ed ^ a_ek[127:0] ^ {128{a_em}};
  assign b_eo = b_ed ^ b_ek[127:0] ^ {128{b_em}};

  lea_job_arbiter #(.LATENCY(4)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_mode(a_r0m),
    .req0_key(a_r0k), .req0_text(a_r0t),
    .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_mode(a_r1m),
    .req1_key(a_r1k), .req1_text(a_r1t),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_rid), .rsp_data(a_rd),
    .eng_mode(a_em), .eng_key(a_ek), .eng_din(a_ed), .eng_dout(a_eo),
    .busy(a_busy)
  );

  lea_job_arbiter #(.LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_mode(b_r0m),
    .req0_key(b_r0k), .req0_text(b_r0t),
    .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_mode(b_r1m),
    .req1_key(b_r1k), .req1_text(b_r1t),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_rid), .rsp_data(b_rd),
    .eng_mode(b_em), .eng_key(b_ek), .eng_din(b_ed), .eng_dout(b_eo),
    .busy(b_busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [191:0] act,
                     input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", n, act, req);
    end
  endtask

  task automatic pop_chk(input string tag, ref exp_t q[$],
                         input logic id, input logic [127:0] d);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_rsp_id"}, 192'(id), 192'(e.id));
      chk({tag, "_rsp_data"}, 192'(d), 192'(e.data));
    end
  endtask

  int   a_acc, b_acc;
  logic a_pv, b_pv;

  always @(negedge clk) begin
    if (rst) begin
      a_pv = 1'b0;
      b_pv = 1'b0;
    end else begin
      if ((a_r0v && a_r0r) || (a_r1v && a_r1r)) a_acc = cyc;
      if ((b_r0v && b_r0r) || (b_r1v && b_r1r)) b_acc = cyc;
      if (a_rv && !a_pv) chk("a_latency", 192'(cyc - a_acc), 192'(5));
      if (b_rv && !b_pv) chk("b_latency", 192'(cyc - b_acc), 192'(2));
      if (a_rv && a_rr) pop_chk("a", qa, a_rid, a_rd);
      if (b_rv && b_rr) pop_chk("b", qb, b_rid, b_rd);
      a_pv = a_rv;
      b_pv = b_rv;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic m,
                      input logic [191:0] k, input logic [127:0] t);
    int n;
    if (id) begin
      a_r1m = m; a_r1k = k; a_r1t = t; a_r1v = 1'b1;
    end else begin
      a_r0m = m; a_r0k = k; a_r0t = t; a_r0v = 1'b1;
    end
    #1;
    for (n = 0; n < 40 && !(id ? a_r1r : a_r0r); n++) begin
      @(posedge clk);
      #2;
    end
    if (n == 40) chk("accept_timeout", 0, 1);
    tick();
    if (id) a_r1v = 1'b0;
    else a_r0v = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 60 && (qa.size() != 0 || qb.size() != 0); n++) tick();
    if (qa.size() != 0 || qb.size() != 0) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int acc, prev, n;
    rst = 1'b1;
    {a_r0v, a_r0m, a_r1v, a_r1m} = '0;
    {b_r0v, b_r0m, b_r1v, b_r1m} = '0;
    a_r0k = '0; a_r0t = '0; a_r1k = '0; a_r1t = '0;
    b_r0k = '0; b_r0t = '0; b_r1k = '0; b_r1t = '0;
    a_rr = 1'b1;
    b_rr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset mid-RUN drops the job and restores last_grant
    send(1'b1, 1'b0, K1, X1);
    tick();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rsp_valid", 192'(a_rv), 0);
    chk("rst_busy", 192'(a_busy), 0);
    chk("rst_rsp_id", 192'(a_rid), 0);
    chk("rst_rsp_data", 192'(a_rd), 0);
    chk("rst_eng_mode", 192'(a_em), 0);
    chk("rst_eng_key", a_ek, 0);
    chk("rst_eng_din", 192'(a_ed), 0);

    // contention: alternating grants, 6-cycle spacing
    a_r0m = 1'b0; a_r0k = KA; a_r0t = XA; a_r0v = 1'b1;
    a_r1m = 1'b0; a_r1k = KB; a_r1t = XB; a_r1v = 1'b1;
    #1;
    chk("first_contention", 192'({a_r0r, a_r1r}), 192'(2'b10));
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) qa.push_back({1'b0, XA ^ KA[127:0]});
      else qa.push_back({1'b1, XB ^ KB[127:0]});
    end
    acc = 0;
    prev = 0;
    for (n = 0; n < 100 && acc < 6; n++) begin
      if ((a_r0v && a_r0r) || (a_r1v && a_r1r)) begin
        chk("grant_order", 192'(a_r1r), 192'(acc % 2));
        if (acc > 0) chk("accept_spacing", 192'(cyc - prev), 192'(6));
        prev = cyc;
        acc++;
      end
      @(posedge clk);
      #2;
    end
    a_r0v = 1'b0;
    a_r1v = 1'b0;
    chk("contention_accepts", 192'(acc), 192'(6));
    drain();

    // single job, readies low through RUN and RESP
    qa.push_back({1'b0, X2 ^ K2[127:0]});
    send(1'b0, 1'b0, K2, X2);
    a_r0v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("run_readies", 192'({a_r0r, a_r1r}), 0);
      if (i == 4) a_r0v = 1'b0;
      tick();
    end
    drain();

    // response backpressure
    a_rr = 1'b0;
    qa.push_back({1'b0, X3 ^ K3[127:0]});
    qa.push_back({1'b1, X4 ^ K4[127:0]});
    send(1'b0, 1'b0, K3, X3);
    a_r1m = 1'b0; a_r1k = K4; a_r1t = X4; a_r1v = 1'b1;
    for (n = 0; n < 20 && !a_rv; n++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 192'(a_rv), 1);
      chk("bp_rsp_data", 192'(a_rd), 192'(X3 ^ K3[127:0]));
      chk("bp_rsp_id", 192'(a_rid), 0);
      chk("bp_readies", 192'({a_r0r, a_r1r}), 0);
      chk("bp_eng_key", a_ek, K3);
      chk("bp_eng_din", 192'(a_ed), 192'(X3));
      tick();
    end
    a_rr = 1'b1;
    tick();
    #1;
    chk("bp_idle_busy", 192'(a_busy), 0);
    chk("bp_idle_ready1", 192'(a_r1r), 1);
    tick();
    a_r1v = 1'b0;
    drain();

    // operand stability while inputs churn
    qa.push_back({1'b0, X5 ^ K5[127:0]});
    send(1'b0, 1'b0, K5, X5);
    for (int i = 0; i < 4; i++) begin
      a_r0k = K5 ^ 192'(i + 7);
      a_r0t = ~X5 + 128'(i);
      #1;
      chk("stab_eng_key", a_ek, K5);
      chk("stab_eng_din", 192'(a_ed), 192'(X5));
      tick();
    end
    drain();

    // decrypt on LATENCY=1 instance
    qb.push_back({1'b1, ~(X6 ^ K6[127:0])});
    b_r1m = 1'b1; b_r1k = K6; b_r1t = X6; b_r1v = 1'b1;
    #1;
    for (n = 0; n < 40 && !b_r1r; n++) begin
      @(posedge clk);
      #2;
    end
    if (n == 40) chk("b_accept_timeout", 0, 1);
    tick();
    b_r1v = 1'b0;
    chk("b_eng_mode", 192'(b_em), 1);
    chk("b_busy", 192'(b_busy), 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
